// File: rtl/gpio_in_conditioner.sv
// GPIO input conditioner: 2-flop sync, optional per-bit tick debounce, edge pulses, W1C sticky status, masked irq.
// Latency pad->gpio_i_o 3 cycles when bypassed, tick-dependent when debounced; no backpressure, outputs valid every cycle.
module gpio_in_conditioner #(
    parameter int WIDTH    = 32,
    parameter int DIV_W    = 16,
    parameter int STABLE_N = 4
) (
    input  logic             PCLK,
    input  logic             PRESET,
    input  logic [WIDTH-1:0] pad_i,
    input  logic [WIDTH-1:0] db_en,
    input  logic [DIV_W-1:0] db_div,
    input  logic [WIDTH-1:0] irq_mask,
    input  logic [WIDTH-1:0] clr_i,
    output logic [WIDTH-1:0] gpio_i_o,
    output logic [WIDTH-1:0] rise_o,
    output logic [WIDTH-1:0] fall_o,
    output logic [WIDTH-1:0] edge_status,
    output logic             irq_o
);

    localparam int                CNT_W    = $clog2(STABLE_N);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(STABLE_N - 1);

    logic [WIDTH-1:0] s1;
    logic [WIDTH-1:0] s2;
    logic [WIDTH-1:0] clean;
    logic [WIDTH-1:0] clean_nxt;
    logic [WIDTH-1:0] clean_d;
    logic [CNT_W-1:0] cnt     [WIDTH];
    logic [CNT_W-1:0] cnt_nxt [WIDTH];
    logic [DIV_W-1:0] div_cnt;
    logic             tick;

    // Plain two-flop synchroniser; nothing may sit between the stages.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            s1 <= pad_i;
            s2 <= s1;
        end
    end

    // >= rather than == so a lowered db_div mid-count fires at once instead of wrapping.
    assign tick = (div_cnt >= db_div);

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            div_cnt <= '0;
        end else if (tick) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + DIV_W'(1);
        end
    end

    // Holding cnt at 0 while bypassed also gives the clear-on-mode-toggle behaviour.
    always_comb begin
        clean_nxt = clean;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_nxt[i] = cnt[i];
            if (!db_en[i]) begin
                cnt_nxt[i]   = '0;
                clean_nxt[i] = s2[i];
            end else if (tick) begin
                if (s2[i] == clean[i]) begin
                    cnt_nxt[i] = '0;
                end else if (cnt[i] == CNT_LAST) begin
                    clean_nxt[i] = s2[i];
                    cnt_nxt[i]   = '0;
                end else begin
                    cnt_nxt[i] = cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            clean   <= '0;
            clean_d <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            clean   <= clean_nxt;
            clean_d <= clean;
            cnt     <= cnt_nxt;
        end
    end

    assign gpio_i_o = clean;
    assign rise_o   = clean & ~clean_d;
    assign fall_o   = ~clean & clean_d;

    // A new edge in the same cycle as a clear strobe keeps the bit set.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            edge_status <= '0;
            irq_o       <= 1'b0;
        end else begin
            edge_status <= (edge_status & ~clr_i) | rise_o | fall_o;
            irq_o       <= |(edge_status & irq_mask);
        end
    end

endmodule

// File: tb/tb_gpio_in_conditioner.sv
// Self-checking bench for gpio_in_conditioner: vector table through a latency scoreboard plus hand-written corner sequences.
module tb_gpio_in_conditioner;
    localparam int WIDTH    = 32;
    localparam int DIV_W    = 16;
    localparam int STABLE_N = 4;

    logic             PCLK = 1'b0;
    logic             PRESET;
    logic [WIDTH-1:0] pad_i;
    logic [WIDTH-1:0] db_en;
    logic [DIV_W-1:0] db_div;
    logic [WIDTH-1:0] irq_mask;
    logic [WIDTH-1:0] clr_i;
    logic [WIDTH-1:0] gpio_i_o;
    logic [WIDTH-1:0] rise_o;
    logic [WIDTH-1:0] fall_o;
    logic [WIDTH-1:0] edge_status;
    logic             irq_o;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct packed {
        logic [31:0] pad;
        logic [31:0] rise;
        logic [31:0] fall;
    } vec_t;

    typedef struct {
        int          due;
        logic [31:0] gpio;
        logic [31:0] rise;
        logic [31:0] fall;
    } exp_t;

    vec_t vecs [10];
    exp_t sb [$];

    always #5 PCLK = ~PCLK;

    gpio_in_conditioner #(
        .WIDTH    (WIDTH),
        .DIV_W    (DIV_W),
        .STABLE_N (STABLE_N)
    ) dut (
        .PCLK        (PCLK),
        .PRESET      (PRESET),
        .pad_i       (pad_i),
        .db_en       (db_en),
        .db_div      (db_div),
        .irq_mask    (irq_mask),
        .clr_i       (clr_i),
        .gpio_i_o    (gpio_i_o),
        .rise_o      (rise_o),
        .fall_o      (fall_o),
        .edge_status (edge_status),
        .irq_o       (irq_o)
    );

    task automatic step();
        @(posedge PCLK);
        #1;
        cyc++;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic chk_bit(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b, expected %b (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic pop_due();
        exp_t e;
        while (sb.size() > 0 && sb[0].due <= cyc) begin
            e = sb.pop_front();
            chk("tbl_gpio", gpio_i_o, e.gpio);
            chk("tbl_rise", rise_o, e.rise);
            chk("tbl_fall", fall_o, e.fall);
        end
    endtask

    task automatic settle_and_clear();
        repeat (6) step();
        clr_i = '1;
        step();
        clr_i = '0;
        step();
    endtask

    initial begin
        int   t;
        int   lat;
        logic seen;
        exp_t e;

        // pad, expected rise, expected fall (previous pad value is all-ones)
        vecs[0] = '{32'h0000_0000, 32'h0000_0000, 32'hFFFF_FFFF};
        vecs[1] = '{32'h0000_0020, 32'h0000_0020, 32'h0000_0000};
        vecs[2] = '{32'h0000_0000, 32'h0000_0000, 32'h0000_0020};
        vecs[3] = '{32'hA5A5_5A5A, 32'hA5A5_5A5A, 32'h0000_0000};
        vecs[4] = '{32'h5A5A_A5A5, 32'h5A5A_A5A5, 32'hA5A5_5A5A};
        vecs[5] = '{32'h5A5A_A5A5, 32'h0000_0000, 32'h0000_0000};
        vecs[6] = '{32'hFFFF_FFFF, 32'hA5A5_5A5A, 32'h0000_0000};
        vecs[7] = '{32'h0000_0001, 32'h0000_0000, 32'hFFFF_FFFE};
        vecs[8] = '{32'h0000_0001, 32'h0000_0000, 32'h0000_0000};
        vecs[9] = '{32'h8000_0000, 32'h8000_0000, 32'h0000_0001};

        PRESET   = 1'b1;
        pad_i    = 32'hFFFF_FFFF;
        db_en    = '0;
        db_div   = '0;
        irq_mask = '0;
        clr_i    = '0;

        // Reset with pads high, then the single legitimate rise.
        for (int i = 0; i < 3; i++) begin
            step();
            chk("rst_levels", gpio_i_o | rise_o | fall_o, 32'h0);
            chk("rst_status", edge_status, 32'h0);
            chk_bit("rst_irq", irq_o, 1'b0);
        end
        PRESET = 1'b0;
        step();
        chk("post_rst_e1", gpio_i_o, 32'h0);
        step();
        chk("post_rst_e2", gpio_i_o, 32'h0);
        step();
        chk("post_rst_gpio", gpio_i_o, 32'hFFFF_FFFF);
        chk("post_rst_rise", rise_o, 32'hFFFF_FFFF);
        chk("post_rst_status_pre", edge_status, 32'h0);
        step();
        chk("post_rst_rise_end", rise_o, 32'h0);
        chk("post_rst_status", edge_status, 32'hFFFF_FFFF);
        chk_bit("post_rst_irq_masked", irq_o, 1'b0);
        clr_i = '1;
        step();
        clr_i = '0;
        chk("post_rst_clear", edge_status, 32'h0);

        // Back-to-back pass-through vectors, checked three cycles after drive.
        for (int i = 0; i < 10; i++) begin
            pad_i  = vecs[i].pad;
            e.due  = cyc + 3;
            e.gpio = vecs[i].pad;
            e.rise = vecs[i].rise;
            e.fall = vecs[i].fall;
            sb.push_back(e);
            step();
            pop_due();
        end
        for (int k = 0; k < 10 && sb.size() > 0; k++) begin
            step();
            pop_due();
        end
        chk("tbl_drained", sb.size(), 32'h0);
        step();
        chk("tbl_status_sticky", edge_status, 32'hFFFF_FFFF);
        chk_bit("tbl_irq_masked", irq_o, 1'b0);

        // Pass-through latency and irq timing on bit 5.
        pad_i = '0;
        settle_and_clear();
        irq_mask = 32'h0000_0020;
        pad_i    = 32'h0000_0020;
        step();
        step();
        chk_bit("lat_gpio_early", gpio_i_o[5], 1'b0);
        step();
        chk_bit("lat_gpio", gpio_i_o[5], 1'b1);
        chk_bit("lat_rise", rise_o[5], 1'b1);
        chk_bit("lat_irq_early", irq_o, 1'b0);
        step();
        chk_bit("lat_rise_end", rise_o[5], 1'b0);
        chk_bit("lat_status", edge_status[5], 1'b1);
        chk_bit("lat_irq_n3", irq_o, 1'b0);
        step();
        chk_bit("lat_irq", irq_o, 1'b1);

        // Clear strobe coinciding with a new fall on bit 3.
        irq_mask = 32'h0000_0008;
        pad_i    = 32'h0000_0008;
        settle_and_clear();
        chk("race_pre_status", edge_status, 32'h0);
        pad_i = '0;
        repeat (3) step();
        chk_bit("race_fall", fall_o[3], 1'b1);
        clr_i = 32'h0000_0008;
        step();
        clr_i = '0;
        chk_bit("race_set_wins", edge_status[3], 1'b1);
        step();
        chk_bit("race_irq", irq_o, 1'b1);
        clr_i = 32'h0000_0008;
        step();
        clr_i = '0;
        chk_bit("clr_status", edge_status[3], 1'b0);
        chk_bit("clr_irq_lag", irq_o, 1'b1);
        step();
        chk_bit("clr_irq_drop", irq_o, 1'b0);
        irq_mask = '0;

        // Debounce on bit 0, tick every 10 cycles.
        db_en  = 32'h0000_0001;
        db_div = 16'd9;
        repeat (30) step();
        seen  = 1'b0;
        pad_i = 32'h0000_0001;
        repeat (25) begin
            step();
            if (gpio_i_o[0]) seen = 1'b1;
        end
        pad_i = '0;
        repeat (60) begin
            step();
            if (gpio_i_o[0]) seen = 1'b1;
        end
        chk_bit("glitch_reject", seen, 1'b0);
        t     = cyc;
        lat   = -1;
        pad_i = 32'h0000_0001;
        for (int k = 0; k < 100; k++) begin
            step();
            if (gpio_i_o[0]) begin
                lat = cyc - t;
                break;
            end
        end
        $display("debounce accept latency: %0d cycles", lat);
        chk_bit("db_accept_window", (lat >= 31 && lat <= 43), 1'b1);
        chk_bit("db_accept_rise", rise_o[0], 1'b1);
        pad_i = '0;
        repeat (60) step();
        chk_bit("db_release", gpio_i_o[0], 1'b0);

        // Divider: db_div drops from 100 to 2 with div_cnt at 50.
        PRESET = 1'b1;
        db_div = 16'd100;
        db_en  = 32'h0000_0002;
        pad_i  = 32'h0000_0002;
        step();
        PRESET = 1'b0;
        repeat (50) step();
        chk_bit("div_no_tick_yet", gpio_i_o[1], 1'b0);
        db_div = 16'd2;
        repeat (9) step();
        chk_bit("div_before_accept", gpio_i_o[1], 1'b0);
        step();
        chk_bit("div_accept", gpio_i_o[1], 1'b1);

        // db_div = 0: accept on the STABLE_N-th cycle after the synchroniser.
        db_div = '0;
        db_en  = 32'h0000_0004;
        repeat (5) step();
        pad_i = 32'h0000_0006;
        repeat (5) step();
        chk_bit("div0_before", gpio_i_o[2], 1'b0);
        step();
        chk_bit("div0_accept", gpio_i_o[2], 1'b1);

        // Reset with cnt[7] at 2 restarts the whole accept sequence.
        db_en = 32'h0000_0080;
        pad_i = '0;
        repeat (5) step();
        pad_i = 32'h0000_0080;
        repeat (4) step();
        chk_bit("mid_db_pending", gpio_i_o[7], 1'b0);
        PRESET = 1'b1;
        step();
        PRESET = 1'b0;
        chk("mid_db_reset_gpio", gpio_i_o, 32'h0);
        repeat (5) step();
        chk_bit("mid_db_restart_before", gpio_i_o[7], 1'b0);
        step();
        chk_bit("mid_db_restart_accept", gpio_i_o[7], 1'b1);
        chk_bit("mid_db_restart_rise", rise_o[7], 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
